// File: rtl/seq_det_pkg.sv
// Shared constants and FSM encoding for the serial pattern-detector scheduler.
package seq_det_pkg;

    localparam int unsigned PATTERN_LEN = 12;
    localparam logic [PATTERN_LEN-1:0] PATTERN = 12'b1110_1101_1011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    any,
    output logic [NREQ-1:0]         grant_oh,
    output logic [$clog2(NREQ)-1:0] grant_idx
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] idx;

    always_comb begin
        any       = 1'b0;
        grant_oh  = '0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IW'((32'(ptr) + i) % NREQ);
            if (!any && req[idx]) begin
                any           = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Shares one serial 12-bit pattern detector among NREQ requesters, one word at a time.
// Optional macro SEQ_DET_CTRL_FIRSTPOS_EN adds res_first_o (index of the first match end).
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32,
    parameter int unsigned CW   = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ*W-1:0]         req_data_i,
    output logic [NREQ-1:0]           req_ready_o,
    output logic                      det_clr_o,
    output logic                      det_x_o,
    input  logic                      det_i,
    output logic                      res_valid_o,
    output logic [$clog2(NREQ)-1:0]   res_id_o,
    output logic [CW-1:0]             res_count_o,
`ifdef SEQ_DET_CTRL_FIRSTPOS_EN
    output logic [$clog2(W+1)-1:0]    res_first_o,
`endif
    input  logic                      res_ready_i
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned KW = $clog2(W);
    localparam logic [KW-1:0] K_LAST  = KW'(W - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt;
    logic [NREQ-1:0] gnt_oh;
    logic [W-1:0]    word;
    logic [KW-1:0]   k;
    logic [CW-1:0]   count;
    logic            hit;

    logic            arb_any;
    logic [NREQ-1:0] arb_oh;
    logic [IW-1:0]   arb_idx;

    logic [W-1:0]    req_words [NREQ];

    for (genvar r = 0; r < NREQ; r++) begin : g_unpack
        assign req_words[r] = req_data_i[r*W +: W];
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid_i),
        .ptr       (ptr),
        .any       (arb_any),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx)
    );

    // Detector output lags the shifted bit by one cycle: skip k=0, catch the last bit in DRAIN.
    assign hit = det_i && (((state == SHIFT) && (k != '0)) || (state == DRAIN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_oh <= '0;
            word   <= '0;
            k      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt    <= arb_idx;
                        gnt_oh <= arb_oh;
                        state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    word  <= req_words[gnt];
                    k     <= '0;
                    ptr   <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);
                    state <= SHIFT;
                end
                SHIFT: begin
                    word <= {word[W-2:0], 1'b0};
                    if (k == K_LAST) begin
                        state <= DRAIN;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DRAIN: begin
                    state <= REPORT;
                end
                REPORT: begin
                    if (res_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (state == CLEAR) begin
            count <= '0;
        end else if (hit && (count != CNT_MAX)) begin
            count <= count + CW'(1);
        end
    end

    assign req_ready_o = (state == CLEAR) ? gnt_oh : '0;
    assign det_clr_o   = (state == CLEAR);
    assign det_x_o     = (state == SHIFT) && word[W-1];
    assign res_valid_o = (state == REPORT);
    assign res_id_o    = res_valid_o ? gnt : '0;
    assign res_count_o = res_valid_o ? count : '0;

`ifdef SEQ_DET_CTRL_FIRSTPOS_EN
    localparam int unsigned FW = $clog2(W + 1);

    logic [FW-1:0] first;

    // A pulse seen at step k marks a match ending on bit k-1; in DRAIN it is bit W-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            first <= '0;
        end else if (state == CLEAR) begin
            first <= FW'(W);
        end else if (hit && (first == FW'(W))) begin
            first <= (state == DRAIN) ? FW'(W - 1) : FW'(k) - FW'(1);
        end
    end

    assign res_first_o = res_valid_o ? first : '0;
`endif

endmodule
